stack_ctrl: RTL
===============

# stack_ctrl

- **Purpose:** Upstream controller for the `stackmem` 34-bit × 8192 data stack.
- **What it does:** Accepts push, pop and peek commands over a valid/ready handshake. Owns the stack pointer and occupancy flags. Drives the memory's address, write-enable and data.
- **Pop/peek data:** Returned one cycle after issue, because the memory read is synchronous. Overflow and underflow are caught here and never corrupt memory.
- **Placement:** Between the execution-unit stack-op decode and `stackmem`.

## Interface
Parameters:
- IA_WIDTH, 13, stack address width; depth = 2^IA_WIDTH entries
- D_WIDTH, 34, data width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - reset_n_i  in  1  asynchronous active-low reset
- Command channel:
  - cmd_valid_i  in  1  command present
  - cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i
  - cmd_op_i  in  2  stack_pkg::stack_op_t: 00 PUSH, 01 POP, 10 PEEK, 11 reserved
  - cmd_data_i  in  D_WIDTH  push data
- Response channel:
  - rsp_valid_o  out  1  one-cycle pulse carrying POP/PEEK result
  - rsp_data_o  out  D_WIDTH  result data; 0 when rsp_err_o
  - rsp_err_o  out  1  response invalid (underflow/illegal)
- Memory side:
  - mem_we_o  out  1  to stackmem write_en_i
  - mem_addr_o  out  IA_WIDTH  to stackmem addr_i
  - mem_din_o  out  D_WIDTH  to stackmem din_i
  - mem_dout_i  in  D_WIDTH  from stackmem dout_o
- Status:
  - depth_o  out  IA_WIDTH+1  current entry count
  - empty_o  out  1  depth_o == 0
  - full_o  out  1  depth_o == 2^IA_WIDTH
  - err_o  out  1  sticky error flag
  - err_code_o  out  2  stack_pkg::stack_err_t: 00 NONE, 01 OVERFLOW, 10 UNDERFLOW, 11 ILLEGAL
  - err_clr_i  in  1  clears err_o/err_code_o

## Operation
- **State:**
  - sp register (IA_WIDTH+1 bits) = depth_o.
  - FSM states: IDLE, RD_WAIT.
- **IDLE:** cmd_ready_o=1.
- **IDLE + PUSH, not full:**
  - mem_we_o=1, mem_addr_o=sp[IA_WIDTH-1:0], mem_din_o=cmd_data_i.
  - sp+1. Stay IDLE.
- **IDLE + PUSH, full:** mem_we_o=0, sp unchanged, error OVERFLOW. Stay IDLE.
- **IDLE + POP, not empty:** mem_addr_o=sp-1, sp-1, go to RD_WAIT.
- **IDLE + PEEK, not empty:** mem_addr_o=sp-1, sp unchanged, go to RD_WAIT.
- **IDLE + POP/PEEK, empty:** no memory access, error UNDERFLOW, go to RD_WAIT with response flagged error.
- **IDLE + op 11:** no memory access, error ILLEGAL, go to RD_WAIT with response flagged error. Every non-push command gets exactly one response.
- **RD_WAIT:**
  - cmd_ready_o=0, rsp_valid_o=1.
  - rsp_data_o=mem_dout_i (or 0 with rsp_err_o=1).
  - Return to IDLE unconditionally; no response backpressure.
- **Error flag:** err_o/err_code_o is sticky.
  - Set on any error; a later error overwrites the code.
  - err_clr_i clears it.
  - A new error in the same cycle as err_clr_i wins.
- **Idle outputs:** mem_addr_o/mem_din_o = 0 when not driven; mem_we_o is high only on a legal push.

## Timing
- **Reset values:**
  - sp=0, state IDLE, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0.
  - mem_we_o=0, mem_addr_o=0, mem_din_o=0.
  - empty_o=1, full_o=0, err_o=0, err_code_o=NONE.
- **Memory signals:** combinational from the accepted command in the same cycle.
- **Status and responses:** registered. depth_o, empty_o and full_o are decoded from sp.
- **Push throughput:** 1 per cycle, back-to-back.
- **Push-then-pop:** a pop accepted the cycle after a push reads the just-written entry, because the memory write precedes the read.
- **Pop/peek latency:** response exactly 1 cycle after acceptance. Maximum rate is 1 command per 2 cycles.
- **Wrap-around:** sp never wraps.
  - At 2^IA_WIDTH entries, push is refused.
  - At 0, pop/peek is refused.
- **Reset mid-operation:**
  - Reset asserted during RD_WAIT suppresses the pending response.
  - Memory contents are not cleared, but sp=0 renders them unreachable.

## Configuration
- **STACK_PEEK_EN defined:** op 10 performs PEEK as above.
- **STACK_PEEK_EN undefined:** op 10 is treated exactly like op 11: ILLEGAL error, error response, no memory access, sp unchanged.

## Structure
- **Package stack_pkg:**
  - stack_op_t (enum logic [1:0])
  - stack_err_t (enum logic [1:0])
  - stack_state_t (IDLE, RD_WAIT)
  - STACK_D_WIDTH=34, STACK_IA_WIDTH=13
- **Modules:** single module, no sub-module needed; the FSM and sp counter are small. stackmem is instantiated beside stack_ctrl by the parent, not inside it.

## Test plan
Bench uses a behavioural 1-cycle synchronous RAM model.
1. Reset, then push 0x1, 0x2, 0x3 back-to-back → mem_we_o high 3 cycles at addr 0,1,2; depth_o=3.
2. After scenario 1: pop, pop → rsp_data_o=0x3 then 0x2, each 1 cycle after accept; cmd_ready_o low in each RD_WAIT; depth_o=1.
3. Pop on empty after reset → rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0, err_code_o=UNDERFLOW; sp stays 0.
4. Push 8192 entries, then push 0x3FFFFFFFF → full_o=1, mem_we_o=0 on the 8193rd push, err_code_o=OVERFLOW; err_clr_i with a simultaneous overflowing push → err_o stays 1.
5. Push 0xA, peek, with and without STACK_PEEK_EN:
   - Defined: rsp_data_o=0xA, depth_o=1.
   - Undefined: rsp_err_o=1, err_code_o=ILLEGAL.
6. Push 0x5, pop, assert reset_n_i low during RD_WAIT → no rsp_valid_o pulse; all outputs at reset values; empty_o=1.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared types and sizing for the stack controller.
// Optional build macro used by stack_ctrl: STACK_PEEK_EN.
package stack_pkg;

  localparam int STACK_D_WIDTH  = 34;
  localparam int STACK_IA_WIDTH = 13;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } stack_op_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10,
    ERR_ILLEGAL   = 2'b11
  } stack_err_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } stack_state_t;

endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: command and response channels between the stack-op
// decode (master) and the stack controller (slave).
interface stack_ctrl_if
  import stack_pkg::*;
#(
  parameter int D_WIDTH = STACK_D_WIDTH
);

  logic               cmd_valid_i;
  logic               cmd_ready_o;
  stack_op_t          cmd_op_i;
  logic [D_WIDTH-1:0] cmd_data_i;

  logic               rsp_valid_o;
  logic [D_WIDTH-1:0] rsp_data_o;
  logic               rsp_err_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: upstream controller for the stackmem data stack. Owns the
// stack pointer, guards overflow/underflow, drives the memory port and
// returns pop/peek data one cycle after acceptance.
// Build macro: STACK_PEEK_EN enables op 10 as PEEK; otherwise op 10 is
// rejected as ILLEGAL.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int IA_WIDTH = STACK_IA_WIDTH,
  parameter int D_WIDTH  = STACK_D_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n_i,
  stack_ctrl_if.slave         cmd_if,
  output logic                mem_we_o,
  output logic [IA_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0]  mem_din_o,
  input  logic [D_WIDTH-1:0]  mem_dout_i,
  output logic [IA_WIDTH:0]   depth_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                err_o,
  output stack_err_t          err_code_o,
  input  logic                err_clr_i
);

`ifdef STACK_PEEK_EN
  localparam bit PeekEn = 1'b1;
`else
  localparam bit PeekEn = 1'b0;
`endif

  localparam logic [IA_WIDTH:0] DepthMax = {1'b1, {IA_WIDTH{1'b0}}};
  localparam logic [IA_WIDTH:0] SpOne    = {{IA_WIDTH{1'b0}}, 1'b1};

  stack_state_t        state_q, state_d;
  logic [IA_WIDTH:0]   sp_q, sp_d;
  logic                rspErr_q, rspErr_d;
  logic                err_q, err_d;
  stack_err_t          errCode_q, errCode_d;

  logic                isFull;
  logic                isEmpty;
  logic [IA_WIDTH:0]   spMinus1;
  logic                cmdReady;
  logic                newErr;
  stack_err_t          newCode;

  assign isFull   = (sp_q == DepthMax);
  assign isEmpty  = (sp_q == '0);
  assign spMinus1 = sp_q - SpOne;

  // State, stack pointer and sticky error registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      sp_q      <= '0;
      rspErr_q  <= 1'b0;
      err_q     <= 1'b0;
      errCode_q <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      rspErr_q  <= rspErr_d;
      err_q     <= err_d;
      errCode_q <= errCode_d;
    end
  end

  // Command decode: memory port, next state, pointer update and error capture.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    rspErr_d   = 1'b0;
    newErr     = 1'b0;
    newCode    = ERR_NONE;
    cmdReady   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;

    case (state_q)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmd_if.cmd_valid_i) begin
          case (cmd_if.cmd_op_i)
            OP_PUSH: begin
              if (!isFull) begin
                mem_we_o   = 1'b1;
                mem_addr_o = sp_q[IA_WIDTH-1:0];
                mem_din_o  = cmd_if.cmd_data_i;
                sp_d       = sp_q + SpOne;
              end else begin
                newErr  = 1'b1;
                newCode = ERR_OVERFLOW;
              end
            end
            OP_POP, OP_PEEK: begin
              state_d = RD_WAIT;
              if ((cmd_if.cmd_op_i == OP_PEEK) && !PeekEn) begin
                newErr   = 1'b1;
                newCode  = ERR_ILLEGAL;
                rspErr_d = 1'b1;
              end else if (isEmpty) begin
                newErr   = 1'b1;
                newCode  = ERR_UNDERFLOW;
                rspErr_d = 1'b1;
              end else begin
                mem_addr_o = spMinus1[IA_WIDTH-1:0];
                if (cmd_if.cmd_op_i == OP_POP) begin
                  sp_d = spMinus1;
                end
              end
            end
            default: begin
              state_d  = RD_WAIT;
              newErr   = 1'b1;
              newCode  = ERR_ILLEGAL;
              rspErr_d = 1'b1;
            end
          endcase
        end
      end
      RD_WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh error outranks a clear arriving in the same cycle.
    if (newErr) begin
      err_d     = 1'b1;
      errCode_d = newCode;
    end else if (err_clr_i) begin
      err_d     = 1'b0;
      errCode_d = ERR_NONE;
    end else begin
      err_d     = err_q;
      errCode_d = errCode_q;
    end
  end

  assign cmd_if.cmd_ready_o = cmdReady;
  assign cmd_if.rsp_valid_o = (state_q == RD_WAIT);
  assign cmd_if.rsp_err_o   = (state_q == RD_WAIT) && rspErr_q;
  assign cmd_if.rsp_data_o  = ((state_q == RD_WAIT) && !rspErr_q) ? mem_dout_i : '0;

  assign depth_o    = sp_q;
  assign empty_o    = isEmpty;
  assign full_o     = isFull;
  assign err_o      = err_q;
  assign err_code_o = errCode_q;

endmodule
